run_length_fsm: RTL

- Parametrised successor to the team's fixed 4-in-a-row 0/1 sequence-detector FSM.
- Tracks the length of the current run of identical bits on a qualified serial input `w`.
- Flags when the run reaches RUN_LEN. Reports run polarity and saturating length.
- Sits behind serial line/pattern front-ends as a configurable sequence detector.

---
 rtl/run_length_fsm_pkg.sv | 17 +
 rtl/run_length_fsm_sat_counter.sv | 19 +
 rtl/run_length_fsm.sv | 102 ++++++++++
 3 files changed

// File: rtl/run_length_fsm_pkg.sv
// Shared state encoding and helpers for the run-length sequence detector.
package run_fsm_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'b00,
        RUN0 = 2'b01,
        RUN1 = 2'b10
    } state_t;

    // RUN state that corresponds to a given run polarity.
    function automatic state_t run_state(input logic bit_val);
        return bit_val ? RUN1 : RUN0;
    endfunction

endpackage

// File: rtl/run_length_fsm_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         inc,
    input  logic         clear,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/run_length_fsm.sv
// Run-length tracker on a qualified serial bit; flags runs reaching RUN_LEN.
// Optional detection event counter enabled by defining RUN_LENGTH_FSM_EVT_CNT_EN.
module run_length_fsm
    import run_fsm_pkg::*;
#(
    parameter int unsigned RUN_LEN = 4,
    parameter int unsigned CNT_W   = $clog2(RUN_LEN + 1),
    parameter int unsigned EVT_W   = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clr,
    input  logic                in_valid,
    input  logic                w,
    output logic [STATE_W-1:0]  state,
    output logic                run_bit,
    output logic [CNT_W-1:0]    run_cnt,
    output logic                hit,
    output logic                hit_pulse,
    output logic [EVT_W-1:0]    evt_cnt
);

    state_t           state_q;
    state_t           state_d;
    logic             bit_d;
    logic [CNT_W-1:0] cnt_d;
    logic             hit_d;
    logic             pulse_d;

    assign state = state_q;

    // State and run-tracking registers; clr mirrors reset except for evt_cnt.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            state_q   <= IDLE;
            run_bit   <= 1'b0;
            run_cnt   <= '0;
            hit       <= 1'b0;
            hit_pulse <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_bit   <= bit_d;
            run_cnt   <= cnt_d;
            hit       <= hit_d;
            hit_pulse <= pulse_d;
        end
    end

    // Next-state and run-length update.
    always_comb begin
        state_d = state_q;
        bit_d   = run_bit;
        cnt_d   = run_cnt;
        pulse_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = run_state(w);
                    bit_d   = w;
                    cnt_d   = CNT_W'(1);
                end
            end
            RUN0, RUN1: begin
                if (in_valid) begin
                    if (w == run_bit) begin
                        if (run_cnt < CNT_W'(RUN_LEN)) begin
                            cnt_d = run_cnt + CNT_W'(1);
                        end
                        pulse_d = (run_cnt == CNT_W'(RUN_LEN - 1));
                    end else begin
                        state_d = run_state(w);
                        bit_d   = w;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            default: begin
                // Unused encoding recovers to IDLE regardless of in_valid.
                state_d = IDLE;
                bit_d   = 1'b0;
                cnt_d   = '0;
            end
        endcase

        hit_d = (cnt_d == CNT_W'(RUN_LEN));
    end

`ifdef RUN_LENGTH_FSM_EVT_CNT_EN
    sat_counter #(
        .W (EVT_W)
    ) u_evt_cnt (
        .clk   (clk),
        .inc   (hit_pulse),
        .clear (reset),
        .count (evt_cnt)
    );
`else
    assign evt_cnt = '0;
`endif

endmodule
